// File: rtl/cache_bus_pkg.sv
// Shared types for the L1 bus-side sequencer: MESI encodings, FSM states, bus opcodes.
package cache_bus_pkg;
  // Default address width, mirrors ADDRESSSIZE in cache_def_1.v
  localparam int ADDR_W_DEF = 32;
  localparam int MESI_W_DEF = 2;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [2:0] {IDLE, ARB, WB, ADDR, WAIT_DATA, DONE} bus_state_t;
  typedef enum logic [1:0] {NONE, RD, RDX, INV} bus_op_t;
endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for the memory-wait states; only exists when SNOOP_TIMEOUT_EN is defined.
`ifdef SNOOP_TIMEOUT_EN
module bus_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  logic [7:0] cnt;

  // WB and WAIT_DATA are never adjacent, so dropping run between them restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n || !run) cnt <= '0;
    else                cnt <= cnt + 8'd1;
  end

  assign expired = run && (cnt == 8'(LIMIT - 1));
endmodule
`endif

// File: rtl/snoop_bus_ctrl.sv
// Bus-side sequencer for one L1: arbitration, optional victim writeback, opcode issue, fill wait.
// Optional watchdog on the memory waits is enabled by defining SNOOP_TIMEOUT_EN.
module snoop_bus_ctrl
  import cache_bus_pkg::*;
#(
  parameter int ADDRESSSIZE    = ADDR_W_DEF,
  parameter int MESI_SIZE      = MESI_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PrRd,
  input  logic                   PrWr,
  input  logic [ADDRESSSIZE-1:0] Address,
  input  logic                   Hit,
  input  logic [MESI_SIZE-1:0]   Current_MESI_state_proc,
  input  logic [MESI_SIZE-1:0]   Victim_MESI_state,
  input  logic [ADDRESSSIZE-1:0] Victim_Address,
  output logic                   Bus_Req,
  input  logic                   Bus_Grant,
  output logic                   BusRd,
  output logic                   BusRdX,
  output logic                   Invalidate,
  output logic [ADDRESSSIZE-1:0] Address_Com,
  input  logic                   Shared_in,
  output logic                   Shared,
  output logic                   Mem_Wr,
  input  logic                   Mem_Ack,
  input  logic                   Mem_Data_Valid,
  output logic                   Fill_Done,
  output logic                   Stall,
  output logic                   Timeout_Err
);
  bus_state_t             state;
  bus_op_t                op;
  bus_op_t                op_issue;
  logic                   wb;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [ADDRESSSIZE-1:0] victim_q;
  logic                   req;
  logic                   silent_hit;
  logic                   upgrade;
  logic                   need_bus;
  logic                   wd_expire;

  assign req        = PrRd | PrWr;
  assign silent_hit = Hit && (Current_MESI_state_proc == MESI_SIZE'(MESI_M) ||
                              Current_MESI_state_proc == MESI_SIZE'(MESI_E) ||
                              (Current_MESI_state_proc == MESI_SIZE'(MESI_S) && !PrWr));
  assign upgrade    = Hit && PrWr && Current_MESI_state_proc == MESI_SIZE'(MESI_S);
  assign need_bus   = req && !silent_hit;
  assign Stall      = (state != IDLE) || need_bus;

  // A peer may have invalidated our S copy while we waited: fetch the line instead of upgrading
  assign op_issue = (op == INV && Current_MESI_state_proc == MESI_SIZE'(MESI_I)) ? RDX : op;

`ifdef SNOOP_TIMEOUT_EN
  logic err_q;

  bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == WB || state == WAIT_DATA),
    .expired (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (wd_expire) err_q <= 1'b1;
  end

  assign Timeout_Err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign wd_expire   = 1'b0;
  assign Timeout_Err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= NONE;
      wb          <= 1'b0;
      addr_q      <= '0;
      victim_q    <= '0;
      Bus_Req     <= 1'b0;
      BusRd       <= 1'b0;
      BusRdX      <= 1'b0;
      Invalidate  <= 1'b0;
      Address_Com <= '0;
      Shared      <= 1'b0;
      Mem_Wr      <= 1'b0;
      Fill_Done   <= 1'b0;
    end else begin
      Fill_Done <= 1'b0;
      unique case (state)
        IDLE: if (need_bus) begin
          addr_q   <= Address;
          victim_q <= Victim_Address;
          op       <= upgrade ? INV : (PrWr ? RDX : RD);
          wb       <= !upgrade && Victim_MESI_state == MESI_SIZE'(MESI_M);
          Bus_Req  <= 1'b1;
          state    <= ARB;
        end
        ARB: if (Bus_Grant) begin
          if (wb) begin
            Mem_Wr      <= 1'b1;
            Address_Com <= victim_q;
            state       <= WB;
          end else begin
            op          <= op_issue;
            BusRd       <= op_issue == RD;
            BusRdX      <= op_issue == RDX;
            Invalidate  <= op_issue == INV;
            Address_Com <= addr_q;
            state       <= ADDR;
          end
        end
        WB: begin
          if (wd_expire) begin
            Bus_Req     <= 1'b0;
            Mem_Wr      <= 1'b0;
            Address_Com <= '0;
            state       <= IDLE;
          end else if (Mem_Ack) begin
            Mem_Wr      <= 1'b0;
            op          <= op_issue;
            BusRd       <= op_issue == RD;
            BusRdX      <= op_issue == RDX;
            Invalidate  <= op_issue == INV;
            Address_Com <= addr_q;
            state       <= ADDR;
          end
        end
        ADDR: begin
          BusRd       <= 1'b0;
          BusRdX      <= 1'b0;
          Invalidate  <= 1'b0;
          Address_Com <= '0;
          Shared      <= Shared_in;
          if (op == INV) begin
            Fill_Done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (wd_expire) begin
            Bus_Req <= 1'b0;
            state   <= IDLE;
          end else if (Mem_Data_Valid) begin
            Fill_Done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          Bus_Req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: a phase-timeline model predicts every output each cycle.
module tb_snoop_bus_ctrl;
`ifdef SNOOP_TIMEOUT_EN
  localparam int TO_P = 4;
  localparam int TO   = 4;
`else
  localparam int TO_P = 255;
  localparam int TO   = 0;
`endif
  localparam logic [1:0] MI = 2'b00, MS = 2'b01, ME = 2'b10, MM = 2'b11;
  localparam int P_REQ = 0, P_ARB = 1, P_WB = 2, P_ADDR = 3, P_WAIT = 4, P_DONE = 5, P_IDLE = 6;

  logic        clk = 1'b0;
  logic        rst_n, PrRd, PrWr, Hit, Bus_Grant, Shared_in, Mem_Ack, Mem_Data_Valid;
  logic [31:0] Address, Victim_Address, Address_Com;
  logic [1:0]  Current_MESI_state_proc, Victim_MESI_state;
  logic        Bus_Req, BusRd, BusRdX, Invalidate, Shared, Mem_Wr, Fill_Done, Stall, Timeout_Err;

  int          vectors = 0, errors = 0;
  int          cyc_idx = 0, pin_fd = -1, pin_op = -1;
  bit          chk_en = 0, model_shared = 0, model_err = 0;
  logic [40:0] exp_vec = '0;
  logic [40:0] act;

  snoop_bus_ctrl #(.ADDRESSSIZE(32), .MESI_SIZE(2), .TIMEOUT_CYCLES(TO_P)) dut (
    .clk(clk), .rst_n(rst_n), .PrRd(PrRd), .PrWr(PrWr), .Address(Address), .Hit(Hit),
    .Current_MESI_state_proc(Current_MESI_state_proc), .Victim_MESI_state(Victim_MESI_state),
    .Victim_Address(Victim_Address), .Bus_Req(Bus_Req), .Bus_Grant(Bus_Grant), .BusRd(BusRd),
    .BusRdX(BusRdX), .Invalidate(Invalidate), .Address_Com(Address_Com), .Shared_in(Shared_in),
    .Shared(Shared), .Mem_Wr(Mem_Wr), .Mem_Ack(Mem_Ack), .Mem_Data_Valid(Mem_Data_Valid),
    .Fill_Done(Fill_Done), .Stall(Stall), .Timeout_Err(Timeout_Err)
  );

  always #5 clk = ~clk;

  // Output bundle expected in a given transaction phase
  function automatic logic [40:0] exp_of(int c, logic [2:0] opv, logic [31:0] a, logic [31:0] va,
                                         bit need, bit shd, bit err);
    logic br, st;
    logic [2:0] o;
    logic [31:0] ac;
    br = (c == P_ARB) || (c == P_WB) || (c == P_ADDR) || (c == P_WAIT) || (c == P_DONE);
    o  = (c == P_ADDR) ? opv : 3'b000;
    st = br || (c == P_REQ && need);
    ac = (c == P_WB) ? va : ((c == P_ADDR) ? a : 32'h0);
    return {br, o, c == P_WB, c == P_DONE, st, shd, err, ac};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      act = {Bus_Req, BusRd, BusRdX, Invalidate, Mem_Wr, Fill_Done, Stall, Shared, Timeout_Err, Address_Com};
      vectors++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL outputs cyc=%0d got req/rd/rdx/inv/wr/fd/stall/sh/to=%b addr=%h exp %b addr=%h",
                 cyc_idx, act[40:32], act[31:0], exp_vec[40:32], exp_vec[31:0]);
      end
      if (Fill_Done && pin_fd >= 0) begin
        vectors++;
        if (cyc_idx != pin_fd) begin
          errors++;
          $display("FAIL fill_done_cycle got %0d exp %0d", cyc_idx, pin_fd);
        end
      end
      if ((BusRd || BusRdX || Invalidate) && pin_op >= 0) begin
        vectors++;
        if (cyc_idx != pin_op) begin
          errors++;
          $display("FAIL opcode_cycle got %0d exp %0d", cyc_idx, pin_op);
        end
      end
    end
  end

  // Builds the expected phase timeline from the request, then drives it cycle by cycle.
  task automatic run_txn(input bit rd, input bit wr, input bit hit, input logic [1:0] cur,
                         input logic [1:0] vic, input logic [31:0] addr, input logic [31:0] vaddr,
                         input int g, input int a, input int d, input bit shin, input bit drop_i,
                         input int pfd, input int pop);
    int ph[$];
    bit lst[$];
    bit silent, inv, wb, aborted, l, hold;
    logic [2:0] opv;
    int n, c;
    silent  = hit && (cur == MM || cur == ME || (cur == MS && !wr));
    inv     = hit && cur == MS && wr;
    wb      = !inv && !silent && vic == MM;
    opv     = (inv && !drop_i) ? 3'b001 : (wr ? 3'b010 : 3'b100);
    aborted = 0;
    ph.push_back(P_REQ); lst.push_back(1);
    if (!silent) begin
      for (int k = 0; k <= g; k++) begin ph.push_back(P_ARB); lst.push_back(k == g); end
      if (wb) begin
        if (TO > 0 && a + 1 > TO) begin
          for (int k = 0; k < TO; k++) begin ph.push_back(P_WB); lst.push_back(0); end
          aborted = 1;
        end else
          for (int k = 0; k <= a; k++) begin ph.push_back(P_WB); lst.push_back(k == a); end
      end
      if (!aborted) begin
        ph.push_back(P_ADDR); lst.push_back(1);
        if (!(inv && !drop_i)) begin
          if (TO > 0 && d + 1 > TO) begin
            for (int k = 0; k < TO; k++) begin ph.push_back(P_WAIT); lst.push_back(0); end
            aborted = 1;
          end else
            for (int k = 0; k <= d; k++) begin ph.push_back(P_WAIT); lst.push_back(k == d); end
        end
        if (!aborted) begin ph.push_back(P_DONE); lst.push_back(1); end
      end
    end
    ph.push_back(P_IDLE); lst.push_back(1);
    n = ph.size();
    pin_fd = pfd;
    pin_op = pop;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i > 0 && ph[i-1] == P_ADDR) model_shared = shin;
      c = ph[i];
      l = lst[i];
      if (c == P_IDLE && aborted) model_err = 1;
      hold = (i == 0) || (i < n - 2);
      PrRd = hold & rd;
      PrWr = hold & wr;
      Hit  = hit;
      Address        = (i == 0) ? addr : ~addr;
      Victim_Address = (i == 0) ? vaddr : ~vaddr;
      Current_MESI_state_proc = (drop_i && i > 0) ? MI : cur;
      Victim_MESI_state = vic;
      Bus_Grant      = (c == P_REQ) || (c == P_ARB && l);
      Mem_Ack        = (c == P_ARB) || (c == P_WB && l) || (c == P_WAIT && !l);
      Mem_Data_Valid = (c == P_ARB) || (c == P_WB && !l) || (c == P_WAIT && l);
      Shared_in      = (c == P_ADDR) ? shin : ~shin;
      cyc_idx = i;
      exp_vec = exp_of(c, opv, addr, vaddr, !silent, model_shared, model_err);
    end
    @(negedge clk);
  endtask

  task automatic reset_mid;
    logic [31:0] ad;
    ad = 32'hCAFE_0040;
    pin_fd = -1;
    pin_op = -1;
    @(posedge clk); #1;
    PrRd = 1; PrWr = 0; Hit = 0; Current_MESI_state_proc = MI; Victim_MESI_state = MI;
    Address = ad; Victim_Address = 32'h0; Bus_Grant = 0; Mem_Ack = 0; Mem_Data_Valid = 0; Shared_in = 0;
    cyc_idx = 0; exp_vec = exp_of(P_REQ, 3'b100, ad, 32'h0, 1, model_shared, model_err);
    @(posedge clk); #1;
    Bus_Grant = 1;
    cyc_idx = 1; exp_vec = exp_of(P_ARB, 3'b100, ad, 32'h0, 1, model_shared, model_err);
    @(posedge clk); #1;
    Bus_Grant = 0; PrRd = 0; Shared_in = 1;
    cyc_idx = 2; exp_vec = exp_of(P_ADDR, 3'b100, ad, 32'h0, 1, model_shared, model_err);
    @(posedge clk); #1;
    Shared_in = 0; model_shared = 1; rst_n = 0;
    cyc_idx = 3; exp_vec = exp_of(P_WAIT, 3'b100, ad, 32'h0, 1, model_shared, model_err);
    @(posedge clk); #1;
    model_shared = 0; model_err = 0;
    cyc_idx = 4; exp_vec = exp_of(P_IDLE, 3'b100, ad, 32'h0, 1, model_shared, model_err);
    for (int k = 5; k < 8; k++) begin
      @(posedge clk); #1;
      rst_n = 1; Mem_Data_Valid = 1;
      cyc_idx = k;
    end
    @(posedge clk); #1;
    Mem_Data_Valid = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; PrRd = 0; PrWr = 0; Hit = 0; Bus_Grant = 0; Shared_in = 0; Mem_Ack = 0;
    Mem_Data_Valid = 0; Address = 0; Victim_Address = 0;
    Current_MESI_state_proc = MI; Victim_MESI_state = MI;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    // clean read miss: BusRd at c2, Fill_Done at c4, peers report Shared
    run_txn(1, 0, 0, MI, MI, 32'h1234_5670, 32'hDEAD_0000, 0, 0, 0, 1, 0, 4, 2);
    // write miss with Modified victim at 0x1F00: WB c3..c5, BusRdX c6, Fill_Done c9
    run_txn(0, 1, 0, MI, MM, 32'h0000_8840, 32'h0000_1F00, 1, 2, 1, 0, 0, 9, 6);
    // upgrade, grant 5 cycles late: grant c6, Invalidate c7, Fill_Done c8
    run_txn(0, 1, 1, MS, MI, 32'h0000_2200, 32'h0, 5, 0, 0, 1, 0, 8, 7);
    // upgrade, immediate grant: Fill_Done c3
    run_txn(0, 1, 1, MS, MI, 32'h0000_2240, 32'h0, 0, 0, 0, 0, 0, 3, 2);
    // upgrade whose line is invalidated while arbitrating: BusRdX c3, fill wait, Fill_Done c7
    run_txn(0, 1, 1, MS, MM, 32'h0000_3300, 32'h0000_9900, 1, 0, 2, 1, 1, 7, 3);
    // silent hits keep Shared untouched
    run_txn(1, 0, 1, MM, MI, 32'h0000_4400, 32'h0, 0, 0, 0, 0, 0, -1, -1);
    run_txn(0, 1, 1, ME, MM, 32'h0000_4480, 32'h0, 0, 0, 0, 0, 0, -1, -1);
    run_txn(1, 0, 1, MS, MI, 32'h0000_44C0, 32'h0, 0, 0, 0, 0, 0, -1, -1);
    // PrRd and PrWr together act as a write
    run_txn(1, 1, 0, MI, MM, 32'hA000_0000, 32'hB000_0000, 2, 0, 0, 0, 0, -1, -1);
    run_txn(1, 1, 1, MS, MI, 32'hA000_0100, 32'h0, 0, 0, 0, 1, 0, 3, 2);
    // read miss with writeback, ack at once
    run_txn(1, 0, 0, MI, MM, 32'hFFFF_FFC0, 32'h8000_0040, 0, 0, 0, 0, 0, 5, 3);
    reset_mid();
    // long fill wait: completes normally, or trips the watchdog when it is built in
`ifdef SNOOP_TIMEOUT_EN
    run_txn(1, 0, 0, MI, MI, 32'h0000_5500, 32'h0, 0, 0, 8, 1, 0, -1, -1);
`else
    run_txn(1, 0, 0, MI, MI, 32'h0000_5500, 32'h0, 0, 0, 8, 1, 0, 12, 2);
`endif
    run_txn(1, 0, 0, MI, MI, 32'h0000_6600, 32'h0, 1, 0, 1, 0, 0, 6, 3);
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
